// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED read-path checker: code geometry helpers
// and the per-beat error classification.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_CLEAN = 2'd0,
        ECC_CE    = 2'd1,
        ECC_UE    = 2'd2
    } ecc_class_e;

    // Number of Hamming check bits: smallest P with 2^P >= data_w + P + 1.
    function automatic int ecc_p(input int data_w);
        int p;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if ((2 ** p) < (data_w + p + 1)) begin
                p = p + 1;
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    // Codeword position of data bit k: the k-th non-power-of-two position
    // counting upward from 3.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int q = 3; q < 512; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == k) begin
                    pos = q;
                end else begin
                    pos = pos;
                end
                cnt = cnt + 1;
            end else begin
                cnt = cnt;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// Read-beat stream bundle: capture side (in_*) and host side (out_*).
interface ecc_secded_pipe_if
    import ecc_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 28
);
    localparam int ECC_W = ecc_p(DATA_W) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ECC_W-1:0]  in_ecc;
    logic [ADDR_W-1:0] in_addr;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ce;
    logic              out_ue;
    logic [ECC_W-1:0]  out_syndrome;

    modport master (
        output in_valid, in_data, in_ecc, in_addr, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_ce, out_ue, out_syndrome
    );

    modport slave (
        input  in_valid, in_data, in_ecc, in_addr, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_ce, out_ue, out_syndrome
    );

endinterface

// File: rtl/ecc_secded_enc.sv
// Combinational extended-Hamming generator: check bits plus overall parity.
// Shared between the read-side syndrome recomputation and the write path.
module ecc_secded_enc
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int P      = ecc_p(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [P-1:0]      o_hamming,
    output logic              o_parity
);

    // Each set data bit contributes its position index to the check word.
    logic [P-1:0] w_term [DATA_W];
    logic [P-1:0] w_hamming;

    genvar k;
    for (k = 0; k < DATA_W; k++) begin : g_term
        localparam int           POS   = data_pos(k);
        localparam logic [P-1:0] POS_V = POS[P-1:0];
        assign w_term[k] = POS_V & {P{i_data[k]}};
    end

    // Fold the per-bit position terms into the Hamming check bits.
    always_comb begin
        w_hamming = {P{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            w_hamming = w_hamming ^ w_term[i];
        end
    end

    assign o_hamming = w_hamming;
    assign o_parity  = (^i_data) ^ (^w_hamming);

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED checker/corrector for the DDR3 read return path with
// valid/ready flow control, saturating CE/UE counters and first-error log.
module ecc_secded_pipe
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int ADDR_W = 28,
    parameter  int CNT_W  = 16,
    localparam int P      = ecc_p(DATA_W),
    localparam int ECC_W  = P + 1,
    localparam int N      = DATA_W + P
) (
    input  logic                clk,
    input  logic                rst_n,
    ecc_secded_pipe_if.slave    bus,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    ce_count,
    output logic [CNT_W-1:0]    ue_count,
    output logic                log_valid,
    output logic [ADDR_W-1:0]   log_addr,
    output logic                log_ue
);

    localparam logic [P-1:0]     N_P     = N[P-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Flow control: a stage moves when empty or when its consumer moves.
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_out_fire;

    // Syndrome recomputation on the incoming beat.
    logic [P-1:0] w_hamming;
    logic         w_parity;
    logic [P-1:0] w_s_in;
    logic         w_pe_in;

    // Stage 1: raw beat plus syndrome.
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [ECC_W-1:0]  r_s1_syn;

    // Decode of stage 1.
    logic [P-1:0]      w_s;
    logic              w_pe;
    ecc_class_e        w_cls;
    logic [DATA_W-1:0] w_flip;
    logic [DATA_W-1:0] w_corr;

    // Stage 2: corrected beat and flags, drives the outputs directly.
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [ADDR_W-1:0] r_s2_addr;
    logic              r_s2_ce;
    logic              r_s2_ue;
    logic [ECC_W-1:0]  r_s2_syn;

    assign w_s2_adv     = (~r_s2_valid) | bus.out_ready;
    assign w_s1_adv     = (~r_s1_valid) | w_s2_adv;
    assign w_out_fire   = r_s2_valid & bus.out_ready;
    assign bus.in_ready = w_s1_adv;

    ecc_secded_enc #(.DATA_W(DATA_W)) u_enc (
        .i_data    (bus.in_data),
        .o_hamming (w_hamming),
        .o_parity  (w_parity)
    );

    // The encoder parity already folds in the recomputed check bits; XOR-ing
    // the syndrome cancels them and leaves the received check bits instead.
    assign w_s_in  = w_hamming ^ bus.in_ecc[P-1:0];
    assign w_pe_in = w_parity ^ (^w_s_in) ^ bus.in_ecc[P];

    // Stage 1 register: capture each accepted beat with its syndrome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {DATA_W{1'b0}};
            r_s1_addr  <= {ADDR_W{1'b0}};
            r_s1_syn   <= {ECC_W{1'b0}};
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_data <= bus.in_data;
                r_s1_addr <= bus.in_addr;
                r_s1_syn  <= {w_pe_in, w_s_in};
            end
        end
    end

    assign w_s  = r_s1_syn[P-1:0];
    assign w_pe = r_s1_syn[P];

    // Classify stage 1: odd weight with an in-range syndrome is correctable.
    always_comb begin
        w_cls = ECC_CLEAN;
        if (!w_pe) begin
            if (w_s == {P{1'b0}}) begin
                w_cls = ECC_CLEAN;
            end else begin
                w_cls = ECC_UE;
            end
        end else begin
            if (w_s > N_P) begin
                w_cls = ECC_UE;
            end else begin
                w_cls = ECC_CE;
            end
        end
    end

    // Only a data position can match; check-bit and parity errors flip nothing.
    genvar k;
    for (k = 0; k < DATA_W; k++) begin : g_flip
        localparam int           POS   = data_pos(k);
        localparam logic [P-1:0] POS_V = POS[P-1:0];
        assign w_flip[k] = (w_cls == ECC_CE) && (w_s == POS_V);
    end

    assign w_corr = r_s1_data ^ w_flip;

    // Stage 2 register: corrected data and flags; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= {DATA_W{1'b0}};
            r_s2_addr  <= {ADDR_W{1'b0}};
            r_s2_ce    <= 1'b0;
            r_s2_ue    <= 1'b0;
            r_s2_syn   <= {ECC_W{1'b0}};
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_corr;
                r_s2_addr <= r_s1_addr;
                r_s2_ce   <= (w_cls == ECC_CE);
                r_s2_ue   <= (w_cls == ECC_UE);
                r_s2_syn  <= r_s1_syn;
            end
        end
    end

    assign bus.out_valid    = r_s2_valid;
    assign bus.out_data     = r_s2_data;
    assign bus.out_addr     = r_s2_addr;
    assign bus.out_ce       = r_s2_ce;
    assign bus.out_ue       = r_s2_ue;
    assign bus.out_syndrome = r_s2_syn;

    // Error counters: bump once per delivered beat, saturate, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_count <= {CNT_W{1'b0}};
            ue_count <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            ce_count <= {CNT_W{1'b0}};
            ue_count <= {CNT_W{1'b0}};
        end else begin
            if (w_out_fire && r_s2_ce && (ce_count != CNT_MAX)) begin
                ce_count <= ce_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_out_fire && r_s2_ue && (ue_count != CNT_MAX)) begin
                ue_count <= ue_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // First-error log: sticky until cleared; clear masks a same-cycle error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_valid <= 1'b0;
            log_addr  <= {ADDR_W{1'b0}};
            log_ue    <= 1'b0;
        end else if (cnt_clr) begin
            log_valid <= 1'b0;
            log_addr  <= {ADDR_W{1'b0}};
            log_ue    <= 1'b0;
        end else if (w_out_fire && (r_s2_ce || r_s2_ue) && !log_valid) begin
            log_valid <= 1'b1;
            log_addr  <= r_s2_addr;
            log_ue    <= r_s2_ue;
        end
    end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe with a queue-based scoreboard.
module tb_ecc_secded_pipe;

    localparam int DW = 64;
    localparam int AW = 28;
    localparam int CW = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [27:0] a;
        logic        ce;
        logic        ue;
        logic [7:0]  syn;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cnt_clr;
    logic [CW-1:0] ce_count;
    logic [CW-1:0] ue_count;
    logic          log_valid;
    logic [AW-1:0] log_addr;
    logic          log_ue;

    ecc_secded_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ecc_secded_pipe #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .ce_count  (ce_count),
        .ue_count  (ue_count),
        .log_valid (log_valid),
        .log_addr  (log_addr),
        .log_ue    (log_ue)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    pos_tab [DW];
    beat_t sb [$];
    beat_t cur;
    beat_t snap;
    beat_t last_out;
    logic  stalled = 1'b0;

    localparam logic [63:0] GOOD = 64'h0123_4567_89AB_CDEF;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check word = XOR of the positions of all set data bits.
    function automatic logic [7:0] enc(input logic [63:0] d);
        logic [6:0] h;
        h = 7'd0;
        for (int k = 0; k < DW; k++)
            if (d[k]) h = h ^ 7'(pos_tab[k]);
        return {(^d) ^ (^h), h};
    endfunction

    // Reference decode from the codeword view of the received beat.
    function automatic beat_t model(input logic [63:0] d, input logic [7:0] e, input logic [27:0] a);
        logic [6:0] s;
        logic       pe;
        beat_t      r;
        s = 7'd0;
        for (int k = 0; k < DW; k++)
            if (d[k]) s = s ^ 7'(pos_tab[k]);
        for (int i = 0; i < 7; i++)
            if (e[i]) s = s ^ 7'(1 << i);
        pe = ^{d, e};
        r.d = d; r.a = a; r.syn = {pe, s}; r.ce = 1'b0; r.ue = 1'b0;
        if (pe && (s <= 7'd71)) begin
            r.ce = 1'b1;
            for (int k = 0; k < DW; k++)
                if (7'(pos_tab[k]) == s) r.d[k] = ~d[k];
        end else if (pe || (s != 7'd0)) begin
            r.ue = 1'b1;
        end
        return r;
    endfunction

    // One clock of stimulus with scoreboard push/pop and stall-hold checks.
    task automatic cyc(input logic v, input logic [63:0] d, input logic [7:0] e,
                       input logic [27:0] a, input logic ordy, input logic clr,
                       output logic acc);
        beat_t eb;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_ecc    = e;
        bus.in_addr   = a;
        bus.out_ready = ordy;
        cnt_clr       = clr;
        #1;
        chk("in_ready", bus.in_ready, !(sb.size() == 2 && !ordy));
        cur = {bus.out_data, bus.out_addr, bus.out_ce, bus.out_ue, bus.out_syndrome};
        if (stalled) chk("stall_hold", {bus.out_valid, cur}, {1'b1, snap});
        if (bus.out_valid && ordy) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                eb = sb.pop_front();
                chk("out_beat", cur, eb);
                last_out = cur;
            end
        end
        acc = v && bus.in_ready;
        if (acc) sb.push_back(model(d, e, a));
        stalled = bus.out_valid && !ordy;
        snap    = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] e, input logic [27:0] a);
        logic acc;
        cyc(1'b1, d, e, a, 1'b1, 1'b0, acc);
    endtask

    task automatic idle(input int n, input logic clr);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 8'd0, 28'd0, 1'b1, clr, acc);
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] dd;
        logic        acc;
        int          bi;
        int          cn;
        int          kk;

        kk = 0;
        for (int q = 1; q <= 71; q++)
            if ((q & (q - 1)) != 0 && kk < DW) begin pos_tab[kk] = q; kk++; end

        // Reset state
        rst_n = 1'b0; cnt_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.in_ecc = 8'd0;
        bus.in_addr = 28'd0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_regs", {bus.out_data, bus.out_addr, bus.out_ce, bus.out_ue, bus.out_syndrome}, 128'd0);
        chk("rst_counters", {ce_count, ue_count}, 8'd0);
        chk("rst_log", {log_valid, log_addr, log_ue}, 30'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean beat, latency of exactly two cycles
        beat(GOOD, enc(GOOD), 28'h0000100);
        chk("lat1_valid", bus.out_valid, 1'b0);
        idle(1, 1'b0);
        chk("lat2_valid", bus.out_valid, 1'b1);
        chk("clean_data", bus.out_data, GOOD);
        chk("clean_flags", {bus.out_ce, bus.out_ue, bus.out_syndrome}, 10'd0);
        idle(2, 1'b0);

        // Data bit 5 flipped: position 10
        beat(GOOD ^ 64'h20, enc(GOOD), 28'h0000ABC);
        idle(3, 1'b0);
        chk("bit5_data", last_out.d, GOOD);
        chk("bit5_syn", last_out.syn, 8'h8A);
        chk("bit5_ce", {last_out.ce, last_out.ue}, 2'b10);
        chk("bit5_ce_count", ce_count, 4'd1);
        chk("bit5_log", {log_valid, log_addr, log_ue}, {1'b1, 28'h0000ABC, 1'b0});

        // Data bits 0 and 1 flipped: double error
        beat(GOOD ^ 64'h3, enc(GOOD), 28'h0000ABD);
        idle(3, 1'b0);
        chk("dbl_data", last_out.d, GOOD ^ 64'h3);
        chk("dbl_syn", last_out.syn, 8'h06);
        chk("dbl_ue", {last_out.ce, last_out.ue}, 2'b01);
        chk("dbl_ue_count", ue_count, 4'd1);
        chk("dbl_log_kept", {log_valid, log_addr, log_ue}, {1'b1, 28'h0000ABC, 1'b0});

        // Overall parity bit alone, then check bit 2 alone
        beat(GOOD, enc(GOOD) ^ 8'h80, 28'h0000AC0);
        idle(3, 1'b0);
        chk("par_syn", last_out.syn, 8'h80);
        chk("par_data", {last_out.d, last_out.ce}, {GOOD, 1'b1});
        beat(GOOD, enc(GOOD) ^ 8'h04, 28'h0000AC1);
        idle(3, 1'b0);
        chk("chk2_syn", last_out.syn, 8'h84);
        chk("chk2_data", {last_out.d, last_out.ce}, {GOOD, 1'b1});
        chk("ce_count_3", ce_count, 4'd3);

        // Eight back-to-back beats with a three-cycle downstream stall
        bi = 0; cn = 0;
        while (bi < 8 && cn < 60) begin
            base = GOOD + 64'(bi);
            case (bi)
                1, 3, 5, 7: dd = base ^ (64'd1 << (bi * 9));
                6:          dd = base ^ (64'd3 << 20);
                default:    dd = base;
            endcase
            cyc(1'b1, dd, enc(base), 28'h0000200 + 28'(bi), !(cn >= 3 && cn <= 5), 1'b0, acc);
            if (acc) bi++;
            cn++;
        end
        chk("stream_sent", bi, 8);
        idle(3, 1'b0);
        chk("stream_drained", sb.size(), 0);
        chk("stream_ce_count", ce_count, 4'd7);
        chk("stream_ue_count", ue_count, 4'd2);

        // Clear coincident with a CE handshake
        beat(GOOD ^ 64'h4, enc(GOOD), 28'h0000300);
        idle(1, 1'b0);
        idle(1, 1'b1);
        chk("clr_counters", {ce_count, ue_count}, 8'd0);
        chk("clr_log", {log_valid, log_addr, log_ue}, 30'd0);

        // Twenty CE beats saturate a 4-bit counter
        for (int j = 0; j < 20; j++) beat(GOOD ^ (64'd1 << j), enc(GOOD), 28'h0000400 + 28'(j));
        idle(3, 1'b0);
        chk("sat_ce_count", ce_count, 4'd15);
        chk("sat_log", {log_valid, log_addr, log_ue}, {1'b1, 28'h0000400, 1'b0});

        // After a clear, an uncorrectable beat is logged as UE
        idle(1, 1'b1);
        beat(GOOD ^ 64'hC0, enc(GOOD), 28'h0000555);
        idle(3, 1'b0);
        chk("ue_log", {log_valid, log_addr, log_ue}, {1'b1, 28'h0000555, 1'b1});
        chk("ue_count_1", ue_count, 4'd1);

        // Reset with two beats in flight
        beat(GOOD ^ 64'h1, enc(GOOD), 28'h0000600);
        beat(GOOD ^ 64'h2, enc(GOOD), 28'h0000601);
        rst_n = 1'b0;
        #1;
        chk("inflight_rst_valid", bus.out_valid, 1'b0);
        chk("inflight_rst_cnt", {ce_count, ue_count, log_valid}, 9'd0);
        chk("inflight_rst_ready", bus.in_ready, 1'b1);
        sb.delete();
        stalled = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(GOOD + 64'd9, enc(GOOD + 64'd9), 28'h0000700);
        idle(3, 1'b0);
        chk("post_rst_drained", sb.size(), 0);
        chk("post_rst_cnt", {ce_count, ue_count}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
